speaker_receiver: RTL and testbench

//  I2S capture path for the Pmod I2S2 line-in ADC; the receive-side counterpart of speaker_control.

---
 rtl/speaker_receiver.sv | 133 +++++++++++++
 tb/tb_speaker_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/speaker_receiver.sv
// rtl/speaker_receiver.sv - I2S capture path for the Pmod I2S2 line-in ADC
//
// Generates mclk (clk/4), sck (clk/16) and lrck (clk/1024) from a free-running
// 10-bit counter. It deserialises audio_sdout into one left/right pair per frame.
// The pair is presented with a 1-clk sample_valid strobe.
//
// Ports:
//   clk, rst_n                   crystal clock, asynchronous active-low reset
//   en                           capture enable (clocks always run)
//   audio_sdout                  serial data from the ADC
//   audio_mclk/lrck/sck          ADC clocks, all registered
//   audio_left/audio_right       last complete stereo pair, two's complement
//   sample_valid                 1-clk pulse when audio_left/right update
module speaker_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  audio_sdout,
    output logic                  audio_mclk,
    output logic                  audio_lrck,
    output logic                  audio_sck,
    output logic [DATA_WIDTH-1:0] audio_left,
    output logic [DATA_WIDTH-1:0] audio_right,
    output logic                  sample_valid
);

    localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);

    logic [9:0]             cnt_q, cnt_d;
    logic                   mclk_q, mclk_d;
    logic                   sck_q, sck_d;
    logic                   lrck_q, lrck_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   armed_q, armed_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]  left_q, left_d;
    logic [DATA_WIDTH-1:0]  right_q, right_d;
    logic                   valid_q, valid_d;

    logic                   sample_bit;
    logic [4:0]             slot;
    logic                   sample_pt;
    logic                   data_slot;
    logic [DATA_WIDTH-1:0]  shifted;

    assign sample_bit = sync_q[SYNC_STAGES-1];
    assign slot       = cnt_q[8:4];
    // Three clk after the sck rising edge: well clear of the ADC's falling-edge drive.
    assign sample_pt  = (cnt_q[3:0] == 4'd11);
    // Slot 0 is the I2S one-bit delay; slots past the word are padding.
    assign data_slot  = (slot != 5'd0) && (slot <= LAST_SLOT);

    always_comb begin
        cnt_d  = cnt_q + 10'd1;
        // Clocks are registered copies of the next counter value, so they
        // stay exactly aligned with cnt_q and glitch-free.
        mclk_d = cnt_d[1];
        sck_d  = cnt_d[3];
        lrck_d = cnt_d[9];

        sync_d = {sync_q[SYNC_STAGES-2:0], audio_sdout};

        // A frame only counts if en was high at its very first clk and never dropped.
        armed_d = armed_q;
        if (!en) begin
            armed_d = 1'b0;
        end else if (cnt_q == 10'd0) begin
            armed_d = 1'b1;
        end

        // Shifting out the old MSB keeps this legal for DATA_WIDTH == 1.
        shifted  = (shift_q << 1) | DATA_WIDTH'(sample_bit);

        shift_d  = shift_q;
        shadow_d = shadow_q;
        left_d   = left_q;
        right_d  = right_q;
        valid_d  = 1'b0;

        if (sample_pt && data_slot) begin
            shift_d = shifted;
            if (slot == LAST_SLOT) begin
                if (!cnt_q[9]) begin
                    shadow_d = shifted;
                end else if (armed_q && en) begin
                    left_d  = shadow_q;
                    right_d = shifted;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mclk_q   <= 1'b0;
            sck_q    <= 1'b0;
            lrck_q   <= 1'b0;
            sync_q   <= '0;
            armed_q  <= 1'b0;
            shift_q  <= '0;
            shadow_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mclk_q   <= mclk_d;
            sck_q    <= sck_d;
            lrck_q   <= lrck_d;
            sync_q   <= sync_d;
            armed_q  <= armed_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
        end
    end

    assign audio_mclk   = mclk_q;
    assign audio_sck    = sck_q;
    assign audio_lrck   = lrck_q;
    assign audio_left   = left_q;
    assign audio_right  = right_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_speaker_receiver.sv
// tb/tb_speaker_receiver.sv - self-checking bench for speaker_receiver with an I2S ADC model
module tb_speaker_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        audio_sdout = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck, sample_valid;
    logic [15:0] audio_left, audio_right;

    speaker_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .audio_sdout  (audio_sdout),
        .audio_mclk   (audio_mclk),
        .audio_lrck   (audio_lrck),
        .audio_sck    (audio_sck),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Clocks elapsed since reset release; cyc % 1024 is the position in the frame.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ADC model: tracks slots by counting sck falling edges, restarts at lrck edges,
    // drives the next bit just after each sck fall. A frame's words latch at its left slot 0.
    logic [15:0] cur_l = 16'h0, cur_r = 16'h0;
    logic [15:0] frm_l = 16'h0, frm_r = 16'h0;
    logic        fill = 1'b0;
    int          slot = 0;
    logic        half = 1'b0;
    logic        m_prev_sck = 1'b0, m_prev_lrck = 1'b0;

    function automatic logic adc_bit(input logic h, input int s);
        logic [15:0] w;
        w = h ? frm_r : frm_l;
        if (s >= 1 && s <= 16) return w[16 - s];
        return fill;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            slot = 0; half = 1'b0; frm_l = cur_l; frm_r = cur_r;
            m_prev_sck = 1'b0; m_prev_lrck = 1'b0;
        end else begin
            if (m_prev_sck && !audio_sck) begin
                if (audio_lrck != m_prev_lrck) begin
                    slot = 0;
                    half = audio_lrck;
                    if (!audio_lrck) begin frm_l = cur_l; frm_r = cur_r; end
                end else begin
                    slot = slot + 1;
                end
            end
            m_prev_sck  = audio_sck;
            m_prev_lrck = audio_lrck;
        end
        audio_sdout = adc_bit(half, slot);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next pulse; checks its position, payload and 1-clk width.
    task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        int n = 0;
        do begin @(negedge clk); n++; end while (!sample_valid && n < 2100);
        chk({tag, "_seen"}, 32'(sample_valid), 32'd1);
        chk({tag, "_pos"}, 32'(cyc % 1024), 32'd780);
        chk({tag, "_left"}, 32'(audio_left), 32'(el));
        chk({tag, "_right"}, 32'(audio_right), 32'(er));
        @(negedge clk);
        chk({tag, "_width"}, 32'(sample_valid), 32'd0);
    endtask

    // Runs to frame position target, counting any pulses on the way.
    task automatic run_to(input string tag, input int target, output int pulses);
        int n = 0;
        pulses = 0;
        do begin
            @(negedge clk);
            if (sample_valid) pulses++;
            n++;
        end while ((cyc % 1024) != target && n < 2100);
        chk({tag, "_reach"}, 32'(cyc % 1024), 32'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_left"}, 32'(audio_left), 32'd0);
        chk({tag, "_right"}, 32'(audio_right), 32'd0);
        chk({tag, "_clks"}, {29'd0, audio_mclk, audio_sck, audio_lrck}, 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        int          clk_err, edge_err, lr_edges, pulses, first_pulse, p1;
        logic        pv_sck, pv_lrck;
        logic [15:0] hl, hr, ql, qr;

        // Reset and clock generation
        cur_l = 16'hA5C3; cur_r = 16'h3C5A; fill = 1'($urandom); en = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        clk_err = 0; edge_err = 0; lr_edges = 0; pulses = 0; first_pulse = -1;
        pv_sck = 1'b0; pv_lrck = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (audio_mclk !== ((cyc % 4) >= 2))     clk_err++;
            if (audio_sck  !== ((cyc % 16) >= 8))    clk_err++;
            if (audio_lrck !== ((cyc % 1024) >= 512)) clk_err++;
            if (audio_lrck !== pv_lrck) begin
                lr_edges++;
                if (!(pv_sck && !audio_sck)) edge_err++;
            end
            if (sample_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            pv_sck = audio_sck; pv_lrck = audio_lrck;
        end
        chk("clk_periods", 32'(clk_err), 32'd0);
        chk("lrck_on_sck_fall", 32'(edge_err), 32'd0);
        chk("lrck_edges", 32'(lr_edges), 32'd2);
        chk("first_pulse_count", 32'(pulses), 32'd1);
        chk("first_pulse_cyc", 32'(first_pulse), 32'd780);
        chk("first_left", 32'(audio_left), 32'h0000A5C3);
        chk("first_right", 32'(audio_right), 32'h00003C5A);

        // Repeating pulses every 1024 clk
        check_frame("a5c3_f1", 16'hA5C3, 16'h3C5A);
        p1 = cyc;
        check_frame("a5c3_f2", 16'hA5C3, 16'h3C5A);
        chk("pulse_period", 32'(cyc - p1), 32'd1024);

        // Ignored slots carry ones, data slots zero
        cur_l = 16'h0; cur_r = 16'h0; fill = 1'b1;
        check_frame("ignored_slots", 16'h0000, 16'h0000);

        // Alternating extreme words
        fill = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            cur_l = 16'h8000; cur_r = 16'h7FFF;
            check_frame("alt_a", 16'h8000, 16'h7FFF);
            cur_l = 16'h7FFF; cur_r = 16'h8000;
            check_frame("alt_b", 16'h7FFF, 16'h8000);
        end

        // Random words and random padding
        for (int i = 0; i < 4; i++) begin
            ql = 16'($urandom); qr = 16'($urandom);
            cur_l = ql; cur_r = qr; fill = 1'($urandom);
            check_frame("random", ql, qr);
        end
        hl = ql; hr = qr;

        // en dropped in the right half, then raised mid-frame
        cur_l = 16'($urandom); cur_r = 16'($urandom);
        run_to("en_pre", 600, pulses);
        chk("en_pre_pulses", 32'(pulses), 32'd0);
        en = 1'b0;
        run_to("en_off", 1000, pulses);
        chk("en_off_pulses", 32'(pulses), 32'd0);
        chk("en_off_hold_l", 32'(audio_left), 32'(hl));
        chk("en_off_hold_r", 32'(audio_right), 32'(hr));
        run_to("en_low", 300, pulses);
        chk("en_low_pulses", 32'(pulses), 32'd0);
        en = 1'b1;
        run_to("en_rise", 1000, pulses);
        chk("en_rise_pulses", 32'(pulses), 32'd0);
        chk("en_rise_hold_l", 32'(audio_left), 32'(hl));
        chk("en_rise_hold_r", 32'(audio_right), 32'(hr));
        ql = 16'($urandom); qr = 16'($urandom);
        cur_l = ql; cur_r = qr;
        check_frame("en_first", ql, qr);

        // Reset pulsed in right slot 10
        ql = 16'($urandom); qr = 16'($urandom);
        cur_l = ql; cur_r = qr;
        run_to("rst_pre", 677, pulses);
        chk("rst_pre_pulses", 32'(pulses), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (3) @(negedge clk);
        chk_zero("rst_held");
        rst_n = 1'b1;
        check_frame("rst_first", ql, qr);
        chk("rst_first_cyc", 32'(cyc), 32'd781);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
